// File: rtl/vram_arbiter_if.sv
// One requester port of the VRAM arbiter: request fields from the master,
// read data and active-low acknowledge back from the arbiter.
interface vram_arbiter_if #(
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned DATA_W = 16
);
  logic              sel;
  logic [ADDR_W-1:0] addr;
  logic              we;
  logic              ub_n;
  logic              lb_n;
  logic [DATA_W-1:0] di;
  logic [DATA_W-1:0] dout;
  logic              dtack_n;

  modport master (output sel, addr, we, ub_n, lb_n, di, input dout, dtack_n);
  modport slave  (input sel, addr, we, ub_n, lb_n, di, output dout, dtack_n);
endinterface

// File: rtl/vram_arbiter.sv
// Shares the byte-lane VRAM block RAM between the VDP and CPU/DMA ports and
// sequences each access: IDLE -> GRANT -> WAIT -> ACK -> RELEASE.
module vram_arbiter #(
  parameter int unsigned ADDR_W     = 15,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned RAM_LAT    = 1,
  parameter int unsigned MAX_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  vram_arbiter_if.slave     vdp,
  vram_arbiter_if.slave     cpu,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_en_hi,
  output logic              ram_en_lo,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_di,
  input  logic [DATA_W-1:0] ram_do,
  output logic              busy
);
  localparam int unsigned HalfW     = DATA_W / 2;
  localparam logic [3:0]  StreakMax = 4'(MAX_STREAK);
  localparam logic [1:0]  WaitInit  = 2'(RAM_LAT > 1 ? RAM_LAT - 2 : 0);

  typedef enum logic [2:0] {StIdle, StGrant, StWait, StAck, StRelease} state_e;

  state_e            state_q;
  logic              own_cpu_q;
  logic              we_q;
  logic              ub_n_q;
  logic              lb_n_q;
  logic              acked_q;
  logic [1:0]        wait_q;
  logic [3:0]        streak_q;

  logic              cpu_wins;
  logic              own_sel;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_di;
  logic              w_we;
  logic              w_ub_n;
  logic              w_lb_n;
  logic [DATA_W-1:0] rd_data;

  // The CPU only overtakes a pending VDP request once the VDP has used its streak.
  assign cpu_wins = cpu.sel && (!vdp.sel || streak_q == StreakMax);
  assign own_sel  = own_cpu_q ? cpu.sel : vdp.sel;
  assign w_addr   = cpu_wins ? cpu.addr : vdp.addr;
  assign w_di     = cpu_wins ? cpu.di   : vdp.di;
  assign w_we     = cpu_wins ? cpu.we   : vdp.we;
  assign w_ub_n   = cpu_wins ? cpu.ub_n : vdp.ub_n;
  assign w_lb_n   = cpu_wins ? cpu.lb_n : vdp.lb_n;

  assign rd_data[DATA_W-1:HalfW] = ub_n_q ? '0 : ram_do[DATA_W-1:HalfW];
  assign rd_data[HalfW-1:0]      = lb_n_q ? '0 : ram_do[HalfW-1:0];

  assign busy = (state_q != StIdle);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      own_cpu_q   <= 1'b0;
      we_q        <= 1'b0;
      ub_n_q      <= 1'b1;
      lb_n_q      <= 1'b1;
      acked_q     <= 1'b0;
      wait_q      <= '0;
      streak_q    <= '0;
      ram_addr    <= '0;
      ram_di      <= '0;
      ram_en_hi   <= 1'b0;
      ram_en_lo   <= 1'b0;
      ram_we      <= 1'b0;
      vdp.dtack_n <= 1'b1;
      cpu.dtack_n <= 1'b1;
      vdp.dout    <= '0;
      cpu.dout    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (vdp.sel || cpu.sel) begin
            state_q   <= StGrant;
            own_cpu_q <= cpu_wins;
            we_q      <= w_we;
            ub_n_q    <= w_ub_n;
            lb_n_q    <= w_lb_n;
            ram_addr  <= w_addr;
            ram_di    <= w_di;
            ram_en_hi <= !w_ub_n;
            ram_en_lo <= !w_lb_n;
            ram_we    <= w_we;
            if (cpu_wins || !cpu.sel) begin
              streak_q <= '0;
            end else if (streak_q != StreakMax) begin
              streak_q <= streak_q + 4'd1;
            end
          end
        end
        StGrant: begin
          ram_en_hi <= 1'b0;
          ram_en_lo <= 1'b0;
          ram_we    <= 1'b0;
          wait_q    <= WaitInit;
          if (RAM_LAT > 1) begin
            state_q <= StWait;
          end else begin
            state_q <= StAck;
          end
        end
        StWait: begin
          if (wait_q == '0) begin
            state_q <= StAck;
          end else begin
            wait_q <= wait_q - 2'd1;
          end
        end
        StAck: begin
          // First ACK cycle lets the RAM output settle; data is captured as DTACK falls.
          if (!acked_q) begin
            acked_q <= 1'b1;
            if (own_cpu_q) begin
              cpu.dtack_n <= 1'b0;
              if (!we_q) cpu.dout <= rd_data;
            end else begin
              vdp.dtack_n <= 1'b0;
              if (!we_q) vdp.dout <= rd_data;
            end
          end else if (!own_sel) begin
            acked_q     <= 1'b0;
            vdp.dtack_n <= 1'b1;
            cpu.dtack_n <= 1'b1;
            state_q     <= StRelease;
          end
        end
        StRelease: state_q <= StIdle;
        default:   state_q <= StIdle;
      endcase
    end
  end
endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench: two arbiter instances (RAM_LAT 1 and 3) each with a simple
// byte-lane RAM model; expectations are hand-computed constants.
module tb_vram_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, rst3;
  int   n_cmp = 0;
  int   n_bad = 0;

  vram_arbiter_if #(.ADDR_W(15), .DATA_W(16)) v1 (), c1 (), v3 (), c3 ();

  logic [14:0] ra1, ra3;
  logic        eh1, el1, we1, busy1, eh3, el3, we3, busy3;
  logic [15:0] rdi1, rdo1, rdi3, rdo3;

  vram_arbiter #(.ADDR_W(15), .DATA_W(16), .RAM_LAT(1), .MAX_STREAK(4)) dut1 (
    .clk(clk), .rst(rst), .vdp(v1), .cpu(c1), .ram_addr(ra1), .ram_en_hi(eh1),
    .ram_en_lo(el1), .ram_we(we1), .ram_di(rdi1), .ram_do(rdo1), .busy(busy1)
  );

  vram_arbiter #(.ADDR_W(15), .DATA_W(16), .RAM_LAT(3), .MAX_STREAK(4)) dut3 (
    .clk(clk), .rst(rst3), .vdp(v3), .cpu(c3), .ram_addr(ra3), .ram_en_hi(eh3),
    .ram_en_lo(el3), .ram_we(we3), .ram_di(rdi3), .ram_do(rdo3), .busy(busy3)
  );

  // RAM models: output is DEAD unless the access was enabled.
  logic [15:0] mem1 [0:32767];
  logic [15:0] mem3 [0:32767];
  logic [15:0] p3   [0:2];
  always @(posedge clk) begin
    if (eh1 && we1) mem1[ra1][15:8] <= rdi1[15:8];
    if (el1 && we1) mem1[ra1][7:0]  <= rdi1[7:0];
    rdo1 <= (eh1 || el1) ? mem1[ra1] : 16'hDEAD;
    if (eh3 && we3) mem3[ra3][15:8] <= rdi3[15:8];
    if (el3 && we3) mem3[ra3][7:0]  <= rdi3[7:0];
    p3[0] <= (eh3 || el3) ? mem3[ra3] : 16'hDEAD;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign rdo3 = p3[2];

  logic g_hi, g_lo, g_we;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive1(input bit cpu, input bit sel, input logic [14:0] a, input bit we,
                        input bit ub_n, input bit lb_n, input logic [15:0] d);
    if (cpu) begin
      c1.addr = a; c1.we = we; c1.ub_n = ub_n; c1.lb_n = lb_n; c1.di = d; c1.sel = sel;
    end else begin
      v1.addr = a; v1.we = we; v1.ub_n = ub_n; v1.lb_n = lb_n; v1.di = d; v1.sel = sel;
    end
  endtask

  // lat = clocks from the sampling edge in IDLE to dtack_n seen low.
  task automatic acc1(input bit cpu, input logic [14:0] a, input bit we, input bit ub_n,
                      input bit lb_n, input logic [15:0] d, output int lat,
                      output logic [15:0] q);
    drive1(cpu, 1'b1, a, we, ub_n, lb_n, d);
    lat = -1;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 0) begin g_hi = eh1; g_lo = el1; g_we = we1; end
    end while ((cpu ? c1.dtack_n : v1.dtack_n) && lat < 40);
    q = cpu ? c1.dout : v1.dout;
    drive1(cpu, 1'b0, a, we, ub_n, lb_n, d);
    repeat (2) @(negedge clk);
  endtask

  task automatic acc3(input logic [14:0] a, input bit we, input logic [15:0] d,
                      output int lat, output logic [15:0] q);
    v3.addr = a; v3.we = we; v3.ub_n = 1'b0; v3.lb_n = 1'b0; v3.di = d; v3.sel = 1'b1;
    lat = -1;
    do begin
      @(negedge clk);
      lat++;
    end while (v3.dtack_n && lat < 40);
    q = v3.dout;
    v3.sel = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int          lat, vfirst, cfirst, ng, nlow, spurious;
    logic [15:0] q;
    logic [9:0]  order;

    rst = 1'b1; rst3 = 1'b1;
    drive1(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b1, '0);
    drive1(1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b1, '0);
    v3.sel = 1'b0; v3.addr = '0; v3.we = 1'b0; v3.ub_n = 1'b1; v3.lb_n = 1'b1; v3.di = '0;
    c3.sel = 1'b0; c3.addr = '0; c3.we = 1'b0; c3.ub_n = 1'b1; c3.lb_n = 1'b1; c3.di = '0;
    repeat (3) @(negedge clk);
    check("reset vdp_dtack_n", v1.dtack_n, 1);
    check("reset cpu_dtack_n", c1.dtack_n, 1);
    check("reset busy", busy1, 0);
    check("reset enables", {eh1, el1, we1}, 0);
    check("reset vdp_do", v1.dout, 0);
    rst = 1'b0; rst3 = 1'b0;

    // Both requests rise together straight out of reset: VDP first.
    drive1(1'b0, 1'b1, 15'h0010, 1'b1, 1'b0, 1'b0, 16'h1111);
    drive1(1'b1, 1'b1, 15'h0020, 1'b1, 1'b0, 1'b0, 16'h2222);
    vfirst = -1; cfirst = -1;
    for (int k = 0; k < 40 && cfirst < 0; k++) begin
      @(negedge clk);
      if (!v1.dtack_n && vfirst < 0) begin vfirst = k; v1.sel = 1'b0; end
      if (!c1.dtack_n) begin cfirst = k; c1.sel = 1'b0; end
    end
    check("tie vdp ack cycle", vfirst, 2);
    check("tie cpu ack cycle", cfirst, 7);
    repeat (3) @(negedge clk);

    // VDP write then read, RAM_LAT=1.
    acc1(1'b0, 15'h0123, 1'b1, 1'b0, 1'b0, 16'hBEEF, lat, q);
    check("vdp write we", g_we, 1);
    acc1(1'b0, 15'h0123, 1'b0, 1'b0, 1'b0, 16'h0000, lat, q);
    check("vdp read latency", lat, 2);
    check("vdp read data", q, 16'hBEEF);
    check("vdp read lanes", {g_hi, g_lo, g_we}, 3'b110);

    // CPU upper-byte write keeps the lower byte.
    acc1(1'b1, 15'h7FFF, 1'b1, 1'b0, 1'b0, 16'h1234, lat, q);
    acc1(1'b1, 15'h7FFF, 1'b1, 1'b0, 1'b1, 16'hA55A, lat, q);
    check("cpu ub write lanes", {g_hi, g_lo, g_we}, 3'b101);
    check("cpu write keeps do", q, 16'h0000);
    acc1(1'b1, 15'h7FFF, 1'b0, 1'b0, 1'b0, 16'h0000, lat, q);
    check("cpu readback", q, 16'hA534);
    acc1(1'b0, 15'h7FFF, 1'b0, 1'b1, 1'b0, 16'h0000, lat, q);
    check("lower lane read", q, 16'h0034);
    check("lower lane enables", {g_hi, g_lo}, 2'b01);
    acc1(1'b0, 15'h0123, 1'b0, 1'b1, 1'b1, 16'h0000, lat, q);
    check("no lane latency", lat, 2);
    check("no lane data", q, 16'h0000);
    check("no lane enables", {g_hi, g_lo}, 2'b00);

    // Owner holds sel through a long ACK.
    drive1(1'b0, 1'b1, 15'h0123, 1'b0, 1'b0, 1'b0, 16'h0000);
    lat = -1;
    do begin @(negedge clk); lat++; end while (v1.dtack_n && lat < 40);
    check("hold latency", lat, 2);
    nlow = 0;
    for (int k = 0; k < 10; k++) begin
      if (!v1.dtack_n) nlow++;
      if (k < 9) @(negedge clk);
    end
    check("hold dtack cycles", nlow, 10);
    v1.sel = 1'b0;
    @(negedge clk);
    check("release dtack_n", v1.dtack_n, 1);
    check("release busy", busy1, 1);
    @(negedge clk);
    check("idle after release", busy1, 0);
    spurious = 0;
    repeat (4) begin
      @(negedge clk);
      if (eh1 || el1 || busy1) spurious++;
    end
    check("no second access", spurious, 0);

    // Both ports saturating: streak of 4 VDP grants then one CPU grant.
    order = '0; ng = 0;
    drive1(1'b0, 1'b1, 15'h0123, 1'b0, 1'b0, 1'b0, 16'h0000);
    drive1(1'b1, 1'b1, 15'h7FFF, 1'b0, 1'b0, 1'b0, 16'h0000);
    for (int k = 0; k < 300 && ng < 10; k++) begin
      @(negedge clk);
      if (!v1.dtack_n && ng < 10) begin order[ng] = 1'b0; ng++; v1.sel = 1'b0; end
      else v1.sel = 1'b1;
      if (!c1.dtack_n && ng < 10) begin order[ng] = 1'b1; ng++; c1.sel = 1'b0; end
      else c1.sel = 1'b1;
    end
    v1.sel = 1'b0; c1.sel = 1'b0;
    repeat (12) @(negedge clk);
    check("streak grant count", ng, 10);
    check("streak grant order", order, 10'h210);
    check("streak ends idle", busy1, 0);

    // RAM_LAT=3 instance: reset mid-WAIT.
    acc3(15'h0042, 1'b1, 16'hC3C3, lat, q);
    acc3(15'h0042, 1'b0, 16'h0000, lat, q);
    check("lat3 latency", lat, 4);
    check("lat3 data", q, 16'hC3C3);
    v3.sel = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("lat3 busy in wait", busy3, 1);
    rst3 = 1'b1; v3.sel = 1'b0;
    @(negedge clk);
    rst3 = 1'b0;
    check("mid reset busy", busy3, 0);
    check("mid reset dtack_n", {v3.dtack_n, c3.dtack_n}, 2'b11);
    check("mid reset enables", {eh3, el3, we3}, 0);
    check("mid reset vdp_do", v3.dout, 0);
    acc3(15'h0042, 1'b0, 16'h0000, lat, q);
    check("post reset latency", lat, 4);
    check("post reset data", q, 16'hC3C3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
